keypad_scan_4x4: RTL

Scans a 4x4 matrix keypad by driving one column low at a time and sampling the four row inputs. It debounces a single pressed key and reports it as a 4-bit hex code with a one-cycle valid pulse. It also keeps the last four codes in a 16-bit history, so the value can be routed directly into the 16-bit hex input of the board's 7-segment scan driver. Together the two blocks form the board's user I/O panel: this block is the input scan, the display driver is the output scan.

---
 rtl/keypad_scan_4x4.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: column drive, row sense, frame debounce,
// single-key hex code output and a four-digit code history.
module keypad_scan_4x4 #(
  parameter int iCLK_Freq       = 50000000,
  parameter int SCAN_DIV        = iCLK_Freq >> 12,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic [3:0]  iROW,
  output logic [3:0]  oCOL,
  output logic [3:0]  oKEY,
  output logic        oKEY_VALID,
  output logic        oKEY_HELD,
  output logic [15:0] oDIG
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_N = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    DEB,
    HELD,
    REL
  } state_t;

  state_t        state;
  logic [3:0]    rs_meta;
  logic [3:0]    rs;
  logic [DW-1:0] div;
  logic [1:0]    col;
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_code;
  logic [3:0]    cand;
  logic [3:0]    cnt;

  logic          slot_end;
  logic          frame_end;
  logic [2:0]    hits;
  logic [1:0]    hit_row;
  logic [2:0]    sum;
  logic [1:0]    tot_cnt;
  logic [3:0]    tot_code;
  logic          none;
  logic          single;

  assign slot_end  = (div == DIV_LAST);
  assign frame_end = slot_end && (col == 2'd3);

  // Merge the current column's sample into the running frame result
  always_comb begin
    hits    = 3'd0;
    hit_row = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!rs[i]) begin
        hits    = hits + 3'd1;
        hit_row = 2'(i);
      end
    end
    sum      = {1'b0, acc_cnt} + hits;
    tot_cnt  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    tot_code = (hits != 3'd0) ? {col, hit_row} : acc_code;
    none     = (tot_cnt == 2'd0);
    single   = (tot_cnt == 2'd1);
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      rs_meta <= 4'hF;
      rs      <= 4'hF;
      div     <= '0;
      col     <= 2'd0;
      oCOL    <= 4'b1110;
    end else begin
      rs_meta <= iROW;
      rs      <= rs_meta;
      if (slot_end) begin
        div  <= '0;
        col  <= col + 2'd1;
        oCOL <= ~(4'b0001 << (col + 2'd1));
      end else begin
        div <= div + DW'(1);
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state      <= IDLE;
      acc_cnt    <= 2'd0;
      acc_code   <= 4'd0;
      cand       <= 4'd0;
      cnt        <= 4'd0;
      oKEY       <= 4'd0;
      oKEY_VALID <= 1'b0;
      oKEY_HELD  <= 1'b0;
      oDIG       <= 16'h0000;
    end else begin
      oKEY_VALID <= 1'b0;
      if (slot_end) begin
        if (col == 2'd3) begin
          acc_cnt  <= 2'd0;
          acc_code <= 4'd0;
        end else begin
          acc_cnt  <= tot_cnt;
          acc_code <= tot_code;
        end
      end
      if (frame_end) begin
        unique case (state)
          IDLE: begin
            if (single) begin
              cand <= tot_code;
              cnt  <= 4'd1;
              if (DEB_N == 4'd1) begin
                oKEY       <= tot_code;
                oDIG       <= {oDIG[11:0], tot_code};
                oKEY_VALID <= 1'b1;
                oKEY_HELD  <= 1'b1;
                state      <= HELD;
              end else begin
                state <= DEB;
              end
            end
          end
          DEB: begin
            if (single && tot_code == cand) begin
              cnt <= cnt + 4'd1;
              if (cnt + 4'd1 == DEB_N) begin
                oKEY       <= cand;
                oDIG       <= {oDIG[11:0], cand};
                oKEY_VALID <= 1'b1;
                oKEY_HELD  <= 1'b1;
                state      <= HELD;
              end
            end else begin
              state <= IDLE;
            end
          end
          HELD: begin
            // Roll-over presses are ignored until a full release
            if (none) begin
              cnt <= 4'd1;
              if (DEB_N == 4'd1) begin
                oKEY_HELD <= 1'b0;
                state     <= IDLE;
              end else begin
                state <= REL;
              end
            end
          end
          REL: begin
            if (none) begin
              cnt <= cnt + 4'd1;
              if (cnt + 4'd1 == DEB_N) begin
                oKEY_HELD <= 1'b0;
                state     <= IDLE;
              end
            end else begin
              state <= HELD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
